cache_line_refill: RTL and testbench

Line-fill engine that sits directly below the direct-mapped cache. It accepts a miss request (word address), fetches the 16-word line from backing memory over a pipelined valid/ready request channel with in-order responses, and writes each returned word into the cache data/tag arrays. When the line is complete it signals the cache.

---
 rtl/cache_line_refill.sv | 175 +++++++++++++++++
 tb/tb_cache_line_refill.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_refill.sv
// cache_line_refill: fetches one 16-word line from backing memory and writes it into the cache.
// Latency: first memory request 1 cycle after miss acceptance; fill_done 18 cycles after it with a 1-cycle memory.
// Backpressure: miss_ready only in IDLE; requests stall on mem_req_ready and on MAX_OUTSTANDING; responses never stall.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   miss_*               miss request from the cache (valid/ready, 32-bit word address)
//   mem_req_*            read request channel to backing memory (valid/ready, word address)
//   mem_resp_*           in-order read responses, one word per valid cycle, no backpressure
//   fill_*               registered word writes into the cache data array, tag/index of the line,
//                        and a one-cycle fill_done pulse when the whole line has been written
//
// Build option: define CACHE_REFILL_CWF_EN for critical-word-first ordering (the line starts at
// the missing word and wraps). Without it every line is fetched in offset order 0..15.
module cache_line_refill #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_valid,
   output logic        miss_ready,
   input  logic [31:0] miss_addr,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        fill_we,
   output logic [7:0]  fill_index,
   output logic [3:0]  fill_offset,
   output logic [31:0] fill_data,
   output logic [19:0] fill_tag,
   output logic        fill_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [4:0] LINE_WORDS = 5'd16;
   localparam logic [4:0] MAX_OUT    = 5'(MAX_OUTSTANDING);

   // Line base address (addr[31:4]); tag and index are its upper and lower slices, so they are
   // not stored separately.
   state_t      state_q, state_d;
   logic [27:0] line_q, line_d;
   logic [3:0]  start_q, start_d;
   logic [4:0]  iss_cnt_q, iss_cnt_d;
   logic [4:0]  rsp_cnt_q, rsp_cnt_d;
   logic        fill_we_q, fill_we_d;
   logic [3:0]  fill_offset_q, fill_offset_d;
   logic [31:0] fill_data_q, fill_data_d;
   logic        fill_done_q, fill_done_d;

   logic [3:0]  miss_start;
   logic [4:0]  outstanding;
   logic [3:0]  req_offset;
   logic [3:0]  rsp_offset;
   logic        req_fire;
   logic        resp_take;

`ifdef CACHE_REFILL_CWF_EN
   assign miss_start = miss_addr[3:0];
`else
   // Offset bits of the miss address are irrelevant when lines are always fetched from word 0.
   logic miss_offset_unused;
   assign miss_offset_unused = ^miss_addr[3:0];
   assign miss_start         = 4'd0;
`endif

   // Counts are 5 bits so "all 16 issued/answered" is distinguishable from zero; the 4-bit
   // offsets wrap naturally for critical-word-first ordering.
   assign outstanding = iss_cnt_q - rsp_cnt_q;
   assign req_offset  = start_q + iss_cnt_q[3:0];
   assign rsp_offset  = start_q + rsp_cnt_q[3:0];

   assign mem_req_addr = {line_q, req_offset};
   assign req_fire     = mem_req_valid && mem_req_ready;

   // A response is only meaningful while a line is in flight; anything arriving in IDLE or DONE
   // (e.g. stale traffic after a reset) is dropped.
   assign resp_take = (state_q == ST_FILL) && mem_resp_valid && (rsp_cnt_q < LINE_WORDS);

   always_comb begin
      state_d       = state_q;
      line_d        = line_q;
      start_d       = start_q;
      iss_cnt_d     = iss_cnt_q;
      rsp_cnt_d     = rsp_cnt_q;
      fill_we_d     = 1'b0;
      fill_offset_d = fill_offset_q;
      fill_data_d   = fill_data_q;
      fill_done_d   = 1'b0;
      miss_ready    = 1'b0;
      mem_req_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) begin
               line_d    = miss_addr[31:4];
               start_d   = miss_start;
               iss_cnt_d = 5'd0;
               rsp_cnt_d = 5'd0;
               state_d   = ST_FILL;
            end
         end

         ST_FILL: begin
            // Derived only from registered counts, so valid and address cannot change while a
            // request waits for mem_req_ready.
            mem_req_valid = (iss_cnt_q < LINE_WORDS) && (outstanding < MAX_OUT);

            if (req_fire) begin
               iss_cnt_d = iss_cnt_q + 5'd1;
            end

            if (resp_take) begin
               fill_we_d     = 1'b1;
               fill_offset_d = rsp_offset;
               fill_data_d   = mem_resp_data;
               rsp_cnt_d     = rsp_cnt_q + 5'd1;
               // The last word's write and fill_done land in the same (DONE) cycle.
               if (rsp_cnt_q == 5'd15) begin
                  fill_done_d = 1'b1;
                  state_d     = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         line_q        <= 28'd0;
         start_q       <= 4'd0;
         iss_cnt_q     <= 5'd0;
         rsp_cnt_q     <= 5'd0;
         fill_we_q     <= 1'b0;
         fill_offset_q <= 4'd0;
         fill_data_q   <= 32'd0;
         fill_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         line_q        <= line_d;
         start_q       <= start_d;
         iss_cnt_q     <= iss_cnt_d;
         rsp_cnt_q     <= rsp_cnt_d;
         fill_we_q     <= fill_we_d;
         fill_offset_q <= fill_offset_d;
         fill_data_q   <= fill_data_d;
         fill_done_q   <= fill_done_d;
      end
   end

   assign fill_we     = fill_we_q;
   assign fill_offset = fill_offset_q;
   assign fill_data   = fill_data_q;
   assign fill_done   = fill_done_q;
   // Held from miss acceptance until the next accepted miss; the cache latches the tag on fill_done.
   assign fill_index  = line_q[7:0];
   assign fill_tag    = line_q[27:8];

endmodule

// File: tb/tb_cache_line_refill.sv
module tb_cache_line_refill;

   localparam int MAX_OUT = 4;
`ifdef CACHE_REFILL_CWF_EN
   localparam logic [3:0] CWF_MASK = 4'hF;
`else
   localparam logic [3:0] CWF_MASK = 4'h0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_valid;
   logic        miss_ready;
   logic [31:0] miss_addr;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        fill_we;
   logic [7:0]  fill_index;
   logic [3:0]  fill_offset;
   logic [31:0] fill_data;
   logic [19:0] fill_tag;
   logic        fill_done;

   cache_line_refill #(.MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .fill_we(fill_we), .fill_index(fill_index), .fill_offset(fill_offset),
      .fill_data(fill_data), .fill_tag(fill_tag), .fill_done(fill_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Control knobs for the memory model (written only by the main sequence).
   int ready_mode   = 0;   // 0: always ready, 1: toggle every cycle, 2: random
   int lat_max      = 1;
   bit resp_hold    = 1'b0;
   int credit_given = 0;
   int stray_req    = 0;

   // Logs (written only by the memory/monitor process).
   logic [31:0] req_q[$];
   logic [35:0] fill_q[$];
   int          done_q[$];
   logic [27:0] done_line_q[$];
   int          acc_q[$];
   int          stall_viol = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [3:0] exp_start(input logic [31:0] a);
      return a[3:0] & CWF_MASK;
   endfunction

   // Memory with in-order responses and a monitor of everything the DUT does.
   initial begin : mem_model
      logic [31:0] pend_a[$];
      int          pend_t[$];
      bit          have_stall;
      logic [31:0] stall_addr;
      int          stray_done;
      int          credit_used;
      have_stall     = 1'b0;
      stall_addr     = '0;
      stray_done     = 0;
      credit_used    = 0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend_a.delete();
            pend_t.delete();
            have_stall = 1'b0;
         end else begin
            if (have_stall && (mem_req_valid !== 1'b1 || mem_req_addr !== stall_addr))
               stall_viol++;
            have_stall = mem_req_valid && !mem_req_ready;
            stall_addr = mem_req_addr;
            if (mem_req_valid && mem_req_ready) begin
               req_q.push_back(mem_req_addr);
               pend_a.push_back(mem_req_addr);
               pend_t.push_back(cyc + int'($urandom_range(lat_max, 1)));
            end
            if (fill_we) fill_q.push_back({fill_offset, fill_data});
            if (fill_done) begin
               done_q.push_back(cyc);
               done_line_q.push_back({fill_tag, fill_index});
            end
            if (miss_valid && miss_ready) acc_q.push_back(cyc);
         end
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       mem_req_ready = 1'b1;
            1:       mem_req_ready = !mem_req_ready;
            default: mem_req_ready = 1'($urandom_range(1, 0));
         endcase
         if (rst) begin
            mem_resp_valid = 1'b0;
         end else if (stray_done < stray_req) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            stray_done++;
         end else if (pend_a.size() != 0 && pend_t[0] <= cyc &&
                      (!resp_hold || credit_used < credit_given)) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(pend_a[0]);
            void'(pend_a.pop_front());
            void'(pend_t.pop_front());
            if (resp_hold) credit_used++;
         end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
         end
      end
   end

   task automatic issue_miss(input logic [31:0] a, output int acc_cyc, output bit ok);
      int n0;
      n0 = acc_q.size();
      ok = 1'b0;
      @(posedge clk);
      #1;
      miss_addr  = a;
      miss_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (acc_q.size() > n0) begin
            ok = 1'b1;
            break;
         end
      end
      miss_valid = 1'b0;
      acc_cyc = ok ? acc_q[n0] : -1;
   endtask

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 800; k++) begin
         @(posedge clk);
         #1;
         if (done_q.size() >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [99:0] got;
      rst = 1'b1;
      miss_valid = 1'b0;
      miss_addr  = '0;
      repeat (3) @(posedge clk);
      #1;
      got = {miss_ready, mem_req_valid, mem_req_addr, fill_we, fill_index, fill_offset,
             fill_data, fill_tag, fill_done};
      total++;
      if (got !== {1'b1, 99'd0}) begin
         bad++;
         $display("FAIL reset_in: got=%h required=%h", got, {1'b1, 99'd0});
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      got = {miss_ready, mem_req_valid, mem_req_addr, fill_we, fill_index, fill_offset,
             fill_data, fill_tag, fill_done};
      total++;
      if (got !== {1'b1, 99'd0}) begin
         bad++;
         $display("FAIL reset_out: got=%h required=%h", got, {1'b1, 99'd0});
      end
   endtask

   // One complete line fill checked against the expected request and write order.
   task automatic test_fill(input logic [31:0] a, input int rmode, input int lmax,
                            input bit chk_time, input string name);
      int rb, fb, db, sv, acc;
      bit ok1, ok2;
      logic [3:0]  st, off;
      logic [31:0] exp_a, got_a;
      logic [35:0] exp_f, got_f;
      logic [27:0] got_l;
      rb = req_q.size(); fb = fill_q.size(); db = done_q.size(); sv = stall_viol;
      st = exp_start(a);
      ready_mode = rmode;
      lat_max    = lmax;
      issue_miss(a, acc, ok1);
      wait_done(db + 1, ok2);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (!(ok1 && ok2)) begin
         bad++;
         $display("FAIL %s_timeout: accepted=%0d done=%0d required 1 1", name, ok1, ok2);
      end
      total++;
      if (req_q.size() - rb !== 16) begin
         bad++;
         $display("FAIL %s_req_count: got=%0d required=16", name, req_q.size() - rb);
      end
      for (int i = 0; i < 16; i++) begin
         off   = st + 4'(i);
         exp_a = {a[31:4], off};
         got_a = (rb + i < req_q.size()) ? req_q[rb + i] : 'x;
         total++;
         if (got_a !== exp_a) begin
            bad++;
            $display("FAIL %s_req[%0d]: got=%h required=%h", name, i, got_a, exp_a);
         end
         exp_f = {off, mem_word(exp_a)};
         got_f = (fb + i < fill_q.size()) ? fill_q[fb + i] : 'x;
         total++;
         if (got_f !== exp_f) begin
            bad++;
            $display("FAIL %s_fill[%0d]: got=%h required=%h", name, i, got_f, exp_f);
         end
      end
      total++;
      if (fill_q.size() - fb !== 16) begin
         bad++;
         $display("FAIL %s_fill_count: got=%0d required=16", name, fill_q.size() - fb);
      end
      got_l = (done_q.size() > db) ? done_line_q[db] : 'x;
      total++;
      if (got_l !== a[31:4]) begin
         bad++;
         $display("FAIL %s_tag_index_at_done: got=%h required=%h", name, got_l, a[31:4]);
      end
      total++;
      if ({fill_tag, fill_index} !== a[31:4]) begin
         bad++;
         $display("FAIL %s_tag_index_held: got=%h required=%h", name, {fill_tag, fill_index}, a[31:4]);
      end
      if (chk_time) begin
         total++;
         if (done_q.size() <= db || done_q[db] - acc !== 18) begin
            bad++;
            $display("FAIL %s_latency: got=%0d required=18", name,
                     (done_q.size() > db) ? done_q[db] - acc : -1);
         end
      end
      total++;
      if (stall_viol - sv !== 0) begin
         bad++;
         $display("FAIL %s_stall_stable: changes_while_stalled=%0d required=0", name, stall_viol - sv);
      end
   endtask

   task automatic test_outstanding();
      int rb, fb, db, acc;
      bit ok1, ok2;
      logic [31:0] a;
      a  = $urandom;
      rb = req_q.size(); fb = fill_q.size(); db = done_q.size();
      ready_mode = 0;
      lat_max    = 1;
      resp_hold  = 1'b1;
      issue_miss(a, acc, ok1);
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (req_q.size() - rb !== MAX_OUT) begin
         bad++;
         $display("FAIL outst_issued: got=%0d required=%0d", req_q.size() - rb, MAX_OUT);
      end
      total++;
      if (mem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL outst_valid_low: got=%b required=0", mem_req_valid);
      end
      credit_given++;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (req_q.size() - rb !== MAX_OUT + 1) begin
         bad++;
         $display("FAIL outst_one_more: got=%0d required=%0d", req_q.size() - rb, MAX_OUT + 1);
      end
      total++;
      if (fill_q.size() - fb !== 1 || mem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL outst_after_resp: fills=%0d valid=%b required 1 0", fill_q.size() - fb, mem_req_valid);
      end
      resp_hold = 1'b0;
      wait_done(db + 1, ok2);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (!(ok1 && ok2) || req_q.size() - rb !== 16 || fill_q.size() - fb !== 16) begin
         bad++;
         $display("FAIL outst_complete: ok=%0d%0d reqs=%0d fills=%0d required ok=11 reqs=16 fills=16",
                  ok1, ok2, req_q.size() - rb, fill_q.size() - fb);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, exp_a;
      logic [35:0] exp_f, got_f;
      logic [3:0]  off;
      int na, fb, db, nf, nd;
      bit ok, ok2;
      a = $urandom; b = $urandom;
      na = acc_q.size(); fb = fill_q.size(); db = done_q.size();
      ready_mode = 0;
      lat_max    = 1;
      @(posedge clk);
      #1;
      miss_addr  = a;
      miss_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (acc_q.size() > na) miss_addr = b;
         if (acc_q.size() >= na + 2) begin
            ok = 1'b1;
            break;
         end
      end
      miss_valid = 1'b0;
      wait_done(db + 2, ok2);
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (!(ok && ok2)) begin
         bad++;
         $display("FAIL b2b_timeout: accepted2=%0d done2=%0d required 1 1", ok, ok2);
      end else begin
         total++;
         if (acc_q[na + 1] !== done_q[db] + 1) begin
            bad++;
            $display("FAIL b2b_accept_cycle: got=%0d required=%0d", acc_q[na + 1], done_q[db] + 1);
         end
         total++;
         if (done_q[db] - acc_q[na] !== 18) begin
            bad++;
            $display("FAIL b2b_latency: got=%0d required=18", done_q[db] - acc_q[na]);
         end
      end
      for (int i = 0; i < 32; i++) begin
         off   = exp_start(i < 16 ? a : b) + 4'(i % 16);
         exp_a = {(i < 16) ? a[31:4] : b[31:4], off};
         exp_f = {off, mem_word(exp_a)};
         got_f = (fb + i < fill_q.size()) ? fill_q[fb + i] : 'x;
         total++;
         if (got_f !== exp_f) begin
            bad++;
            $display("FAIL b2b_fill[%0d]: got=%h required=%h", i, got_f, exp_f);
         end
      end
      // Responses while IDLE must not reach the cache.
      nf = fill_q.size(); nd = done_q.size();
      stray_req += 3;
      repeat (8) @(posedge clk);
      #1;
      total++;
      if (fill_q.size() !== nf || done_q.size() !== nd) begin
         bad++;
         $display("FAIL idle_stray: fills=%0d dones=%0d required %0d %0d", fill_q.size(), done_q.size(), nf, nd);
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [99:0] got;
      int fb, nf, nd, acc;
      bit ok;
      fb = fill_q.size();
      ready_mode = 0;
      lat_max    = 1;
      issue_miss($urandom, acc, ok);
      for (int k = 0; k < 100; k++) begin
         if (fill_q.size() - fb >= 5) break;
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      got = {miss_ready, mem_req_valid, mem_req_addr, fill_we, fill_index, fill_offset,
             fill_data, fill_tag, fill_done};
      total++;
      if (!ok || fill_q.size() - fb !== 5 || got !== {1'b1, 99'd0}) begin
         bad++;
         $display("FAIL midreset_outputs: accepted=%0d fills=%0d got=%h required 1 5 %h",
                  ok, fill_q.size() - fb, got, {1'b1, 99'd0});
      end
      nf = fill_q.size(); nd = done_q.size();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      stray_req += 2;
      repeat (10) @(posedge clk);
      #1;
      total++;
      if (fill_q.size() !== nf) begin
         bad++;
         $display("FAIL midreset_no_fill: got=%0d required=%0d", fill_q.size(), nf);
      end
      total++;
      if (done_q.size() !== nd) begin
         bad++;
         $display("FAIL midreset_no_done: got=%0d required=%0d", done_q.size(), nd);
      end
      total++;
      if ({miss_ready, mem_req_valid} !== 2'b10) begin
         bad++;
         $display("FAIL midreset_idle: got=%b required=10", {miss_ready, mem_req_valid});
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         test_fill($urandom, 2, int'($urandom_range(4, 1)), 1'b0, "rand");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill(32'h0000_3A57, 0, 1, 1'b1, "basic");
      test_fill(32'h0000_3A57, 1, 2, 1'b0, "toggle");
      test_outstanding();
      test_back_to_back();
      test_reset_mid_fill();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
